// File: rtl/pcs_pkg.sv
// pcs_pkg: shared constants, types and helpers for the 64b/66b PCS transmit encoder.
//   Sync headers, block type codes, XGMII control characters, 7-bit PCS control codes,
//   TX state / word class enums and the 66-bit block payload struct.
package pcs_pkg;

  localparam int unsigned PCS_DATA_W = 64;
  localparam int unsigned PCS_HEAD_W = 2;

  localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;
  localparam logic [1:0] SYNC_HEAD_DATA = 2'b01;

  localparam logic [7:0] BLOCK_TYPE_CTRL  = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_S0    = 8'h78;
  localparam logic [7:0] BLOCK_TYPE_S4    = 8'h33;
  localparam logic [7:0] BLOCK_TYPE_OS0   = 8'h4b;
  localparam logic [7:0] BLOCK_TYPE_OS4   = 8'h2d;
  localparam logic [7:0] BLOCK_TYPE_OS_OS = 8'h55;
  localparam logic [7:0] BLOCK_TYPE_T0    = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_T1    = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_T2    = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_T3    = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_T4    = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_T5    = 8'hd2;
  localparam logic [7:0] BLOCK_TYPE_T6    = 8'he1;
  localparam logic [7:0] BLOCK_TYPE_T7    = 8'hff;

  localparam logic [7:0] XGMII_CTRL_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_CTRL_START = 8'hfb;
  localparam logic [7:0] XGMII_CTRL_TERM  = 8'hfd;
  localparam logic [7:0] XGMII_CTRL_ERR   = 8'hfe;
  localparam logic [7:0] XGMII_CTRL_ORD   = 8'h9c;

  localparam logic [6:0] PCS_CTRL_IDLE = 7'h00;
  localparam logic [6:0] PCS_CTRL_ERR  = 7'h1e;
  localparam logic [3:0] PCS_ORD_SEQ   = 4'h0;

  // Error block payload: control type with every lane carrying the error code
  localparam logic [63:0] EBLOCK_DATA = {{8{PCS_CTRL_ERR}}, BLOCK_TYPE_CTRL};

  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_e;
  typedef enum logic [2:0] {CLS_C, CLS_S, CLS_D, CLS_T, CLS_E} word_class_e;

  typedef struct packed {
    logic [PCS_HEAD_W-1:0] head;
    logic [PCS_DATA_W-1:0] data;
  } pcs_block_t;

  // Terminate block type for the lane holding /T/
  function automatic logic [7:0] term_type(input logic [2:0] k);
    case (k)
      3'd0:    return BLOCK_TYPE_T0;
      3'd1:    return BLOCK_TYPE_T1;
      3'd2:    return BLOCK_TYPE_T2;
      3'd3:    return BLOCK_TYPE_T3;
      3'd4:    return BLOCK_TYPE_T4;
      3'd5:    return BLOCK_TYPE_T5;
      3'd6:    return BLOCK_TYPE_T6;
      default: return BLOCK_TYPE_T7;
    endcase
  endfunction

  // XGMII idle/error character to its 7-bit PCS control code
  function automatic logic [6:0] ctrl_code(input logic [7:0] ch);
    return (ch == XGMII_CTRL_ERR) ? PCS_CTRL_ERR : PCS_CTRL_IDLE;
  endfunction

endpackage

// File: rtl/xgmii_enc_tx_if.sv
// xgmii_enc_tx_if: XGMII input word plus 66-bit block output bundle of the TX encoder.
//   xgmii_txd_i/xgmii_txc_i/ready_i flow into the encoder, xgmii_ready_o/valid_o/head_o/data_o out.
//   master: traffic source/sink side, slave: encoder side.
interface xgmii_enc_tx_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned HEAD_W = 2
);
  logic [DATA_W-1:0] xgmii_txd_i;
  logic [7:0]        xgmii_txc_i;
  logic              ready_i;
  logic              xgmii_ready_o;
  logic              valid_o;
  logic [HEAD_W-1:0] head_o;
  logic [DATA_W-1:0] data_o;

  modport master (
    output xgmii_txd_i, xgmii_txc_i, ready_i,
    input  xgmii_ready_o, valid_o, head_o, data_o
  );

  modport slave (
    input  xgmii_txd_i, xgmii_txc_i, ready_i,
    output xgmii_ready_o, valid_o, head_o, data_o
  );
endinterface

// File: rtl/xgmii_enc_classify.sv
// xgmii_enc_classify: combinational classifier/encoder for one XGMII word.
//   txd    in  64  XGMII data, lane n = [8n+7:8n]
//   txc    in  8   XGMII control flags
//   cls_c  out     word class C/S/D/T/E
//   block_c out    encoded 66-bit block (EBLOCK for class E)
// Ordered sets are encoded only when XGMII_ENC_ORD_SET_EN is defined.
module xgmii_enc_classify
  import pcs_pkg::*;
#(
  parameter bit IS_40G = 1'b1
) (
  input  logic [63:0] txd,
  input  logic [7:0]  txc,
  output word_class_e cls_c,
  output pcs_block_t  block_c
);

  logic [7:0][7:0] lane;
  logic [7:0]      ie;        // lane is a control idle or error char
  logic [2:0]      term_k;    // first control lane
  logic            upper_ok;
  logic            term_ok;
  logic            all_ctrl;
  logic            s0;
  logic            s4;
  logic [63:0]     c_data;
  logic [63:0]     t_data;
`ifdef XGMII_ENC_ORD_SET_EN
  logic            os0;
  logic            os4;
  logic            os_os;
`endif

  assign lane = txd;

  // Per-lane decode, terminate search and control/terminate payloads
  always_comb begin
    ie       = '0;
    term_k   = 3'd7;
    upper_ok = 1'b1;
    c_data   = '0;
    t_data   = '0;
    for (int i = 0; i < 8; i++) begin
      ie[i] = txc[i] && (lane[i] == XGMII_CTRL_IDLE || lane[i] == XGMII_CTRL_ERR);
      c_data[7*i+8 +: 7] = ctrl_code(lane[i]);
    end
    c_data[7:0] = BLOCK_TYPE_CTRL;
    for (int i = 7; i >= 0; i--) begin
      if (txc[i]) term_k = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > int'(term_k) && !ie[i]) upper_ok = 1'b0;
    end
    t_data[7:0] = term_type(term_k);
    for (int i = 0; i < 7; i++) begin
      if (i < int'(term_k)) t_data[8*i+8 +: 8] = lane[i];
    end
    for (int i = 1; i < 8; i++) begin
      if (i > int'(term_k)) t_data[7*i+8 +: 7] = ctrl_code(lane[i]);
    end
  end

  assign term_ok  = (txc != 8'h00) && (lane[term_k] == XGMII_CTRL_TERM) && upper_ok;
  assign all_ctrl = (txc == 8'hff) && (&ie);
  assign s0       = (txc == 8'h01) && (lane[0] == XGMII_CTRL_START);
  assign s4       = !IS_40G && (txc == 8'h1f) && (&ie[3:0]) && (lane[4] == XGMII_CTRL_START);
`ifdef XGMII_ENC_ORD_SET_EN
  assign os0   = (txc == 8'hf1) && (lane[0] == XGMII_CTRL_ORD) && (&ie[7:4]);
  assign os4   = !IS_40G && (txc == 8'h1f) && (&ie[3:0]) && (lane[4] == XGMII_CTRL_ORD);
  assign os_os = !IS_40G && (txc == 8'h11) && (lane[0] == XGMII_CTRL_ORD) &&
                 (lane[4] == XGMII_CTRL_ORD);
`endif

  // Class priority and block selection
  always_comb begin
    cls_c        = CLS_E;
    block_c.head = SYNC_HEAD_CTRL;
    block_c.data = EBLOCK_DATA;
    if (txc == 8'h00) begin
      cls_c        = CLS_D;
      block_c.head = SYNC_HEAD_DATA;
      block_c.data = txd;
    end else if (all_ctrl) begin
      cls_c        = CLS_C;
      block_c.data = c_data;
    end else if (s0) begin
      cls_c        = CLS_S;
      block_c.data = {txd[63:8], BLOCK_TYPE_S0};
    end else if (s4) begin
      cls_c        = CLS_S;
      block_c.data = {txd[63:40], 4'h0, c_data[35:8], BLOCK_TYPE_S4};
    end else if (term_ok) begin
      cls_c        = CLS_T;
      block_c.data = t_data;
    end
`ifdef XGMII_ENC_ORD_SET_EN
    else if (os0) begin
      cls_c        = CLS_C;
      block_c.data = {c_data[63:36], PCS_ORD_SEQ, txd[31:8], BLOCK_TYPE_OS0};
    end else if (os4) begin
      cls_c        = CLS_C;
      block_c.data = {txd[63:40], PCS_ORD_SEQ, c_data[35:8], BLOCK_TYPE_OS4};
    end else if (os_os) begin
      cls_c        = CLS_C;
      block_c.data = {txd[63:40], PCS_ORD_SEQ, PCS_ORD_SEQ, txd[31:8], BLOCK_TYPE_OS_OS};
    end
`endif
  end

endmodule

// File: rtl/xgmii_enc_tx.sv
// xgmii_enc_tx: 64b/66b PCS transmit encoder with the TX state machine.
//   clk    in   single clock
//   reset  in   asynchronous reset, active high
//   bus    slave modport of xgmii_enc_tx_if:
//            xgmii_txd_i/xgmii_txc_i  XGMII word, ready_i downstream accept,
//            xgmii_ready_o = ready_i, valid_o/head_o/data_o registered 66-bit block.
// Optional feature macro: XGMII_ENC_ORD_SET_EN enables ordered-set encoding (in the classifier).
module xgmii_enc_tx
  import pcs_pkg::*;
#(
  parameter bit          IS_40G = 1'b1,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned HEAD_W = 2
) (
  input logic         clk,
  input logic         reset,
  xgmii_enc_tx_if.slave bus
);

  localparam logic [2:0] ST_INIT = 3'(TX_INIT);
  localparam logic [2:0] ST_C    = 3'(TX_C);
  localparam logic [2:0] ST_D    = 3'(TX_D);
  localparam logic [2:0] ST_T    = 3'(TX_T);
  localparam logic [2:0] ST_E    = 3'(TX_E);

  word_class_e       cls_c;
  pcs_block_t        block_c;
  logic              legal_c;
  logic [2:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] data_q, data_d;

  xgmii_enc_classify #(.IS_40G(IS_40G)) u_classify (
    .txd     (bus.xgmii_txd_i),
    .txc     (bus.xgmii_txc_i),
    .cls_c   (cls_c),
    .block_c (block_c)
  );

  // Next state and next block; everything holds while ready_i is low
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    head_d  = head_q;
    data_d  = data_q;
    legal_c = 1'b0;
    if (bus.ready_i) begin
      valid_d = 1'b1;
      state_d = ST_E;
      case (state_q)
        ST_D: begin
          if (cls_c == CLS_D) begin
            state_d = ST_D; legal_c = 1'b1;
          end else if (cls_c == CLS_T) begin
            state_d = ST_T; legal_c = 1'b1;
          end
        end
        ST_E: begin
          if (cls_c == CLS_C) begin
            state_d = ST_C; legal_c = 1'b1;
          end else if (cls_c == CLS_D) begin
            state_d = ST_D; legal_c = 1'b1;
          end else if (cls_c == CLS_T) begin
            state_d = ST_T; legal_c = 1'b1;
          end
        end
        default: begin  // INIT, C and T share one transition row
          if (cls_c == CLS_C) begin
            state_d = ST_C; legal_c = 1'b1;
          end else if (cls_c == CLS_S) begin
            state_d = ST_D; legal_c = 1'b1;
          end
        end
      endcase
      head_d = legal_c ? HEAD_W'(block_c.head) : HEAD_W'(SYNC_HEAD_CTRL);
      data_d = legal_c ? DATA_W'(block_c.data) : DATA_W'(EBLOCK_DATA);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      valid_q <= 1'b0;
      head_q  <= HEAD_W'(SYNC_HEAD_CTRL);
      data_q  <= DATA_W'(EBLOCK_DATA);
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      data_q  <= data_d;
    end
  end

  assign bus.xgmii_ready_o = bus.ready_i;
  assign bus.valid_o       = valid_q;
  assign bus.head_o        = head_q;
  assign bus.data_o        = data_q;

endmodule

// File: tb/tb_xgmii_enc_tx.sv
// tb_xgmii_enc_tx: scoreboard bench for xgmii_enc_tx, one XLGMII (IS_40G=1) and one XGMII
// (IS_40G=0) instance driven with the same word stream.
module tb_xgmii_enc_tx;
  import pcs_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xgmii_enc_tx_if #(.DATA_W(64), .HEAD_W(2)) bus40 ();
  xgmii_enc_tx_if #(.DATA_W(64), .HEAD_W(2)) bus10 ();

  xgmii_enc_tx #(.IS_40G(1'b1), .DATA_W(64), .HEAD_W(2)) dut40 (
    .clk(clk), .reset(reset), .bus(bus40));
  xgmii_enc_tx #(.IS_40G(1'b0), .DATA_W(64), .HEAD_W(2)) dut10 (
    .clk(clk), .reset(reset), .bus(bus10));

  localparam logic [63:0] IDLE = 64'h0707070707070707;
  localparam logic [65:0] EBLK = {2'b10, {8{7'h1e}}, 8'h1e};

  int checks = 0;
  int errors = 0;
  logic [65:0] exp40_q[$];
  logic [65:0] exp10_q[$];
  logic [65:0] last40, last10;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] ctl(input logic [63:0] d);
    return {2'b10, d};
  endfunction

  function automatic logic [65:0] dat(input logic [63:0] d);
    return {2'b01, d};
  endfunction

  task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic r);
    bus40.xgmii_txd_i = d; bus40.xgmii_txc_i = c; bus40.ready_i = r;
    bus10.xgmii_txd_i = d; bus10.xgmii_txc_i = c; bus10.ready_i = r;
  endtask

  // Drive one accepted word, queue its expected blocks, compare one cycle later
  task automatic send(input string tag, input logic [63:0] d, input logic [7:0] c,
                      input logic [65:0] e40, input logic [65:0] e10);
    drive(d, c, 1'b1);
    exp40_q.push_back(e40);
    exp10_q.push_back(e10);
    #1;
    check({tag, "/rdy"}, 66'(bus40.xgmii_ready_o), 66'(1));
    @(posedge clk);
    #1;
    if (exp40_q.size() == 0 || exp10_q.size() == 0) begin
      check({tag, "/queue"}, 66'(0), 66'(1));
    end else begin
      last40 = exp40_q.pop_front();
      last10 = exp10_q.pop_front();
      check({tag, "/40"}, {bus40.head_o, bus40.data_o}, last40);
      check({tag, "/10"}, {bus10.head_o, bus10.data_o}, last10);
      check({tag, "/valid"}, 66'({bus40.valid_o, bus10.valid_o}), 66'(2'b11));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/40"}, {bus40.head_o, bus40.data_o}, EBLK);
    check({tag, "/10"}, {bus10.head_o, bus10.data_o}, EBLK);
    check({tag, "/valid"}, 66'({bus40.valid_o, bus10.valid_o}), 66'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [65:0] os_exp;
    reset = 1'b1;
    drive(IDLE, 8'hff, 1'b0);
    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    send("idle0", IDLE, 8'hff, ctl(64'h1e), ctl(64'h1e));

    // Start, two data words, terminate in lane 3, back to idle
    send("s0", 64'h07060504030201fb, 8'h01, ctl(64'h0706050403020178), ctl(64'h0706050403020178));
    send("d1", 64'h1122334455667788, 8'h00, dat(64'h1122334455667788), dat(64'h1122334455667788));
    send("d2", 64'h99aabbccddeeff00, 8'h00, dat(64'h99aabbccddeeff00), dat(64'h99aabbccddeeff00));
    send("t3", 64'h07070707fda3a2a1, 8'hf8, ctl(64'h00000000a3a2a1b4), ctl(64'h00000000a3a2a1b4));
    send("idle1", IDLE, 8'hff, ctl(64'h1e), ctl(64'h1e));

    // Data without start is an error, idle recovers
    send("d_bad", 64'h0123456789abcdef, 8'h00, EBLK, EBLK);
    send("idle2", IDLE, 8'hff, ctl(64'h1e), ctl(64'h1e));

    // Error char in an idle word, unknown control char
    send("ierr", 64'h0707070707fe0707, 8'hff, ctl(64'h000000000780001e), ctl(64'h000000000780001e));
    send("unk", 64'h070707075c070707, 8'hff, EBLK, EBLK);
    send("idle3", IDLE, 8'hff, ctl(64'h1e), ctl(64'h1e));

    // Terminate in lane 5 followed by an error char
    send("s0b", 64'h07060504030201fb, 8'h01, ctl(64'h0706050403020178), ctl(64'h0706050403020178));
    send("t5", 64'h07fefde4e3e2e1e0, 8'he0, ctl(64'h0078e4e3e2e1e0d2), ctl(64'h0078e4e3e2e1e0d2));
    send("idle4", IDLE, 8'hff, ctl(64'h1e), ctl(64'h1e));

    // Start in lane 4: error on XLGMII, type 33 on XGMII; terminate lane 0 legal for both
    send("s4", 64'hc3c2c1fb07070707, 8'h1f, EBLK, ctl(64'hc3c2c10000000033));
    send("t0", 64'h07070707070707fd, 8'hff, ctl(64'h87), ctl(64'h87));
    send("idle5", IDLE, 8'hff, ctl(64'h1e), ctl(64'h1e));

    // Lane-0 ordered set
`ifdef XGMII_ENC_ORD_SET_EN
    os_exp = ctl(64'h00000000b3b2b14b);
`else
    os_exp = EBLK;
`endif
    send("os0", 64'h07070707b3b2b19c, 8'hf1, os_exp, os_exp);
    send("idle6", IDLE, 8'hff, ctl(64'h1e), ctl(64'h1e));

    // Back-pressure mid-packet: an idle word offered while stalled must not be consumed
    send("s0c", 64'h07060504030201fb, 8'h01, ctl(64'h0706050403020178), ctl(64'h0706050403020178));
    send("d3", 64'h0123456789abcdef, 8'h00, dat(64'h0123456789abcdef), dat(64'h0123456789abcdef));
    drive(IDLE, 8'hff, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall/40", {bus40.head_o, bus40.data_o}, last40);
      check("stall/10", {bus10.head_o, bus10.data_o}, last10);
      check("stall/rdy", 66'({bus40.xgmii_ready_o, bus10.xgmii_ready_o}), 66'(0));
      check("stall/valid", 66'({bus40.valid_o, bus10.valid_o}), 66'(2'b11));
    end
    send("d4", 64'hfedcba9876543210, 8'h00, dat(64'hfedcba9876543210), dat(64'hfedcba9876543210));
    send("t7", 64'hfd66554433221100, 8'h80, ctl(64'h66554433221100ff), ctl(64'h66554433221100ff));
    send("idle7", IDLE, 8'hff, ctl(64'h1e), ctl(64'h1e));

    // Asynchronous reset in the middle of a packet
    send("s0d", 64'h07060504030201fb, 8'h01, ctl(64'h0706050403020178), ctl(64'h0706050403020178));
    send("d5", 64'h0f0e0d0c0b0a0908, 8'h00, dat(64'h0f0e0d0c0b0a0908), dat(64'h0f0e0d0c0b0a0908));
    #3 reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    #1 reset = 1'b0;
    send("d_init", 64'h0f0e0d0c0b0a0908, 8'h00, EBLK, EBLK);
    send("idle8", IDLE, 8'hff, ctl(64'h1e), ctl(64'h1e));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
